// File: rtl/opcode_decode_stage.sv
// i281 decode front end: 2-entry skid buffer holding pre-decoded one-hot op bus + immediate.
// Optional macro OPDEC_INSTR_COUNT_EN adds a saturating pop counter on instr_count.
module opcode_decode_stage #(
    parameter int INSTR_W = 16,
    parameter int IMM_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [26:0]        op_out,
    output logic [IMM_W-1:0]   imm_out
`ifdef OPDEC_INSTR_COUNT_EN
    ,
    output logic [15:0]        instr_count
`endif
);

    localparam logic [26:0] OP_NOOP = 27'h1;

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    state_t             state, state_nxt;
    logic               acc, pop;
    logic               load_head_in, load_skid_in, head_from_skid, head_clear;
    logic [26:0]        skid_op, dec_op;
    logic [IMM_W-1:0]   skid_imm;

    function automatic logic [26:0] decode(input logic [INSTR_W-1:0] w);
        logic [26:0] oh;
        logic [4:0]  idx;
        case (w[15:12])
            4'h0: idx = 5'd0;
            4'h1: idx = 5'd1 + {3'b000, w[9:8]};
            4'h2: idx = 5'd5;
            4'h3: idx = 5'd6;
            4'h4: idx = 5'd7;
            4'h5: idx = 5'd8;
            4'h6: idx = 5'd9;
            4'h7: idx = 5'd10;
            4'h8: idx = 5'd11;
            4'h9: idx = 5'd12;
            4'hA: idx = 5'd13;
            4'hB: idx = 5'd14;
            4'hC: idx = w[8] ? 5'd16 : 5'd15;
            4'hD: idx = 5'd17;
            4'hE: idx = 5'd18;
            default: idx = 5'd19 + {3'b000, w[9:8]};
        endcase
        oh          = '0;
        oh[idx]     = 1'b1;
        oh[26:25]   = w[11:10];
        oh[24:23]   = w[9:8];
        return oh;
    endfunction

    assign dec_op = decode(in_instr);
    assign acc    = in_valid & in_ready;
    assign pop    = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY:   if (acc) state_nxt = ONE;
                ONE:     if (acc && !pop) state_nxt = TWO;
                         else if (pop && !acc) state_nxt = EMPTY;
                TWO:     if (pop) state_nxt = ONE;
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_comb begin
        out_valid      = (state != EMPTY);
        load_head_in   = 1'b0;
        load_skid_in   = 1'b0;
        head_from_skid = 1'b0;
        head_clear     = 1'b0;
        if (flush) begin
            head_clear = 1'b1;
        end else begin
            case (state)
                EMPTY: load_head_in = acc;
                ONE: begin
                    load_head_in = acc & pop;
                    load_skid_in = acc & ~pop;
                    head_clear   = pop & ~acc;
                end
                TWO:     head_from_skid = pop;
                default: head_clear = 1'b1;
            endcase
        end
    end

    // in_ready is its own flop, precomputed from the next occupancy
    always_ff @(posedge clk) begin
        if (!rst_n) in_ready <= 1'b1;
        else        in_ready <= (state_nxt != TWO);
    end

    // Head is kept at the NOOP/zero pattern whenever empty, so outputs need no gating
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_out   <= OP_NOOP;
            imm_out  <= '0;
            skid_op  <= OP_NOOP;
            skid_imm <= '0;
        end else begin
            if (head_clear) begin
                op_out  <= OP_NOOP;
                imm_out <= '0;
            end else if (load_head_in) begin
                op_out  <= dec_op;
                imm_out <= in_instr[IMM_W-1:0];
            end else if (head_from_skid) begin
                op_out  <= skid_op;
                imm_out <= skid_imm;
            end
            if (load_skid_in) begin
                skid_op  <= dec_op;
                skid_imm <= in_instr[IMM_W-1:0];
            end
        end
    end

`ifdef OPDEC_INSTR_COUNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n)                            instr_count <= '0;
        else if (pop && instr_count != 16'hFFFF) instr_count <= instr_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_opcode_decode_stage.sv
// Randomized + directed bench for opcode_decode_stage against a queue-based reference model.
module tb_opcode_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [15:0] in_instr;
    logic [26:0] op_out;
    logic [7:0]  imm_out;
`ifdef OPDEC_INSTR_COUNT_EN
    logic [15:0] instr_count;
`endif

    int checks = 0;
    int failures = 0;
    logic [34:0] q[$];
    int unsigned cnt = 0;

    always #5 clk = ~clk;

    opcode_decode_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .op_out(op_out), .imm_out(imm_out)
`ifdef OPDEC_INSTR_COUNT_EN
        , .instr_count(instr_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference decode: table of base bit per opcode, plus subop spread for the grouped opcodes
    function automatic logic [34:0] ref_dec(input logic [15:0] w);
        int base[16] = '{0, 1, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 17, 18, 19};
        int opc = int'(w[15:12]);
        int sub = int'(w[9:8]);
        int bitn = base[opc];
        logic [26:0] op;
        if (opc == 1 || opc == 15) bitn += sub;
        if (opc == 12) bitn += sub % 2;
        op = 27'(1) << bitn;
        op = op | (27'(w[11:10]) << 25) | (27'(w[9:8]) << 23);
        return {op, w[7:0]};
    endfunction

    task automatic check_outputs();
        chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
        chk("in_ready", {31'b0, in_ready}, {31'b0, q.size() < 2});
        chk("op_out", {5'b0, op_out}, q.size() > 0 ? {5'b0, q[0][34:8]} : 32'h1);
        chk("imm_out", {24'b0, imm_out}, q.size() > 0 ? {24'b0, q[0][7:0]} : 32'h0);
`ifdef OPDEC_INSTR_COUNT_EN
        chk("instr_count", {16'b0, instr_count}, cnt);
`endif
    endtask

    task automatic step(input logic v, input logic [15:0] w, input logic ordy, input logic fl);
        bit acc, pop;
        in_valid = v; in_instr = w; out_ready = ordy; flush = fl;
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            cnt = 0;
        end else begin
            acc = v && q.size() < 2;
            pop = q.size() > 0 && ordy;
            if (pop && cnt < 32'hFFFF) cnt++;
            if (fl) q.delete();
            else begin
                if (pop) void'(q.pop_front());
                if (acc) q.push_back(ref_dec(w));
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        rst_n = 1'b0;
        step(1, 16'h4600, 1, 0);
        step(1, 16'h4600, 1, 0);
        chk("rst_op", {5'b0, op_out}, 32'h1);
        rst_n = 1'b1;

        step(1, 16'h4600, 1, 0);
        chk("add_op", {5'b0, op_out}, 32'h3000080);
        chk("add_imm", {24'b0, imm_out}, 32'h0);
        step(1, 16'hF205, 1, 0);
        chk("brg_op", {5'b0, op_out}, 32'h1200000);
        chk("brg_imm", {24'b0, imm_out}, 32'h5);

        for (int op = 0; op < 16; op++)
            for (int s = 0; s < 4; s++) begin
                step(1, {op[3:0], 2'($urandom), s[1:0], 8'($urandom)}, 1, 0);
                chk("onehot", {31'b0, $onehot(op_out[22:0])}, 32'h1);
            end
        step(0, 16'h0, 1, 0);

        // backpressure
        step(1, 16'h1300, 0, 0);
        step(1, 16'h6500, 0, 0);
        chk("bp_full", {31'b0, in_ready}, 32'h0);
        step(1, 16'h7777, 0, 0);
        step(0, 16'h0, 1, 0);
        step(0, 16'h0, 1, 0);
        chk("bp_drained", {31'b0, out_valid}, 32'h0);

        // flush from TWO with an incoming word
        step(1, 16'h2123, 0, 0);
        step(1, 16'h3456, 0, 0);
        step(1, 16'hABCD, 1, 1);
        chk("flush_empty", {31'b0, out_valid}, 32'h0);
        step(0, 16'h0, 1, 0);

        for (int i = 0; i < 3000; i++)
            step($urandom_range(3) != 0, 16'($urandom), $urandom_range(2) != 0,
                 $urandom_range(15) == 0);

`ifdef OPDEC_INSTR_COUNT_EN
        for (int i = 0; i < 70000; i++) step(1, 16'($urandom), 1, 0);
        chk("cnt_sat", {16'b0, instr_count}, 32'hFFFF);
        step(1, 16'h1234, 1, 1);
        chk("cnt_flush", {16'b0, instr_count}, 32'hFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
